sum_display_driver: RTL and testbench

- Downstream consumer of the 8-bit adder result.
- Registers the 9-bit result {Cout,S} as an unsigned value from 0 to 511.
- Converts it to three BCD digits with an iterative shift-add-3 (double-dabble) FSM.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display on the FPGA board.

---
 rtl/sum_display_driver.sv | 150 +++++++++++++++
 tb/tb_sum_display_driver.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sum_display_driver.sv
// Latches the 9-bit adder result, converts it to BCD with a shift-add-3 FSM and scans the
// three digits onto a 4-digit common-anode display. Define SUM_DISPLAY_LEADING_ZERO_BLANK_EN to blank leading zeros.
module sum_display_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] S,
    input  logic       Cout,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);
    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t           state_q, state_d;
    logic [8:0]       in_q, last_q, bin_q;
    logic [11:0]      bcd_q, bcd_adj;
    logic [3:0]       iter_q;
    logic [3:0]       d2_q, d1_q, d0_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q;
    logic             busy_q, busy_d;
    logic             blank2, blank1;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Add-3 correction on each BCD nibble before the shift.
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                                 : bcd_q[gi*4 +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_q != last_q) state_d = SHIFT;
            SHIFT:   if (iter_q == 4'd8) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q   <= '0;
            last_q <= '0;
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
            d2_q   <= '0;
            d1_q   <= '0;
            d0_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            in_q   <= {Cout, S};
            busy_q <= busy_d;
            case (state_q)
                IDLE: if (in_q != last_q) begin
                    last_q <= in_q;
                    bin_q  <= in_q;
                    bcd_q  <= '0;
                    iter_q <= '0;
                end
                SHIFT: begin
                    bcd_q  <= {bcd_adj[10:0], bin_q[8]};
                    bin_q  <= {bin_q[7:0], 1'b0};
                    iter_q <= iter_q + 4'd1;
                end
                COMMIT: begin
                    d2_q <= bcd_q[11:8];
                    d1_q <= bcd_q[7:4];
                    d0_q <= bcd_q[3:0];
                end
                default: ;
            endcase
        end
    end

`ifdef SUM_DISPLAY_LEADING_ZERO_BLANK_EN
    assign blank2 = (d2_q == 4'd0);
    assign blank1 = (d2_q == 4'd0) && (d1_q == 4'd0);
`else
    assign blank2 = 1'b0;
    assign blank1 = 1'b0;
`endif

    always_comb begin
        seg_d = 7'h7F;
        case (idx_q)
            2'd0:    seg_d = seg7(d0_q);
            2'd1:    seg_d = blank1 ? 7'h7F : seg7(d1_q);
            2'd2:    seg_d = blank2 ? 7'h7F : seg7(d2_q);
            default: seg_d = 7'h7F;
        endcase
    end

    // Anode and segments are registered together so they never disagree for a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            seg_q <= 7'h7F;
            an_q  <= 4'hF;
        end else begin
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            seg_q <= seg_d;
            an_q  <= ~(4'b0001 << idx_q);
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = 1'b1;
    assign busy = busy_q;
endmodule

// File: tb/tb_sum_display_driver.sv
// Directed bench for sum_display_driver with REFRESH_DIV=4; builds with or without
// SUM_DISPLAY_LEADING_ZERO_BLANK_EN and adjusts the expected leading-zero segments.
module tb_sum_display_driver;
    localparam int DIV = 4;
`ifdef SUM_DISPLAY_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] S = 8'h00;
    logic       Cout = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;
    int checks = 0;
    int failures = 0;

    sum_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .S(S), .Cout(Cout),
        .seg(seg), .an(an), .dp(dp), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for digit idx to be enabled, then checks its segments.
    task automatic show_digit(input string tag, input int idx, input logic [6:0] exp_seg);
        logic [3:0] an_exp;
        int n;
        an_exp = ~(4'b0001 << idx);
        n = 0;
        while (an !== an_exp && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_an"}, an, an_exp);
        check({tag, "_seg"}, seg, exp_seg);
    endtask

    task automatic check_display(input string tag, input logic [6:0] s2, input logic [6:0] s1,
                                 input logic [6:0] s0);
        show_digit({tag, "_d0"}, 0, s0);
        show_digit({tag, "_d1"}, 1, s1);
        show_digit({tag, "_d2"}, 2, s2);
        show_digit({tag, "_d3"}, 3, 7'h7F);
    endtask

    // Called at a negedge with the FSM idle; checks busy is high exactly k+2..k+11.
    task automatic run_conv(input string tag, input logic [7:0] s_v, input logic c_v);
        S = s_v;
        Cout = c_v;
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            check({tag, "_busy"}, busy, (j >= 2 && j <= 11));
        end
        repeat (2) @(negedge clk);
        $display("conv %s value=%0d", tag, {c_v, s_v});
    endtask

    initial begin
        logic [3:0] an_exp;
        logic [6:0] seg_exp;
        int n;

        // Test 1: reset and scan order
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'hF);
        check("rst_dp", dp, 1'b1);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            an_exp = ~(4'b0001 << (j / 4));
            seg_exp = (j / 4 == 0) ? 7'h40 : (j / 4 == 3) ? 7'h7F : LZ;
            check("scan_an", an, an_exp);
            check("scan_seg", seg, seg_exp);
        end
        $display("scan done");

        // Tests 2 and 3
        run_conv("v300", 8'h2C, 1'b1);
        check_display("v300", 7'h30, 7'h40, 7'h40);
        run_conv("v511", 8'hFF, 1'b1);
        check_display("v511", 7'h12, 7'h79, 7'h79);
        run_conv("v0", 8'h00, 1'b0);
        check_display("v0", LZ, LZ, 7'h40);

        // Test 4: change 5 -> 9 mid-conversion, aligned so digit 0 is shown in the gap
        n = 0;
        while (an === 4'hE && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (an !== 4'hE && n < 20) begin @(negedge clk); n++; end
        check("align_an", an, 4'hE);
        S = 8'd5;
        Cout = 1'b0;
        for (int j = 0; j <= 24; j++) begin
            @(negedge clk);
            check("v5to9_busy", busy, (j >= 2 && j <= 11) || (j >= 13 && j <= 22));
            if (an === 4'hE && j >= 12 && j <= 22) check("v5_first_seg", seg, 7'h12);
            if (j == 4) S = 8'd9;
        end
        $display("conv v5to9 value=9");
        check_display("v9", LZ, LZ, 7'h10);

        // Test 5: reset during SHIFT
        S = 8'hFF;
        Cout = 1'b0;
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);
            check("v255_busy", busy, (j >= 2));
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h7F);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_an0", an, 4'hE);
        check("postrst_d0", seg, 7'h40);
        repeat (4) @(negedge clk);
        check("postrst_an1", an, 4'hD);
        check("postrst_d1", seg, LZ);
        repeat (4) @(negedge clk);
        check("postrst_an2", an, 4'hB);
        check("postrst_d2", seg, LZ);
        n = 0;
        while (busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        check("v255_done", busy, 1'b0);
        repeat (2) @(negedge clk);
        $display("conv v255 value=255");
        check_display("v255", 7'h24, 7'h12, 7'h12);

        // Test 6: leading zeros
        run_conv("v7", 8'd7, 1'b0);
        check_display("v7", LZ, LZ, 7'h78);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
